// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM-stage load/store engine with byte-lane steering, load extension and pipeline stall.
module mem_access_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_we,
    input  logic        mem_re,
    input  logic [2:0]  sx_size,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        dbus_valid,
    input  logic        dbus_ready,
    output logic        dbus_we,
    output logic [31:0] dbus_addr,
    output logic [3:0]  dbus_be,
    output logic [31:0] dbus_wdata,
    input  logic        dbus_rvalid,
    input  logic [31:0] dbus_rdata,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        stall,
    output logic        access_fault,
    output logic        bus_err
);
    typedef enum logic [1:0] {IDLE, ADDR, RESP, DONE} state_t;
    localparam int CW = TIMEOUT < 2 ? 1 : $clog2(TIMEOUT + 1);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          valid_q, valid_d, we_q, we_d;
    logic [31:0]   addr_q, addr_d, wdata_q, wdata_d, ld_q, ld_d;
    logic [3:0]    be_q, be_d;
    logic [2:0]    size_q, size_d;
    logic [1:0]    off_q, off_d;
    logic          lv_q, lv_d, af_q, af_d, err_q, err_d;
    logic          req, fault, timed_out;
    logic [3:0]    be_req;
    logic [31:0]   wd_req, shifted, ext;

    assign req     = mem_we | mem_re;
    // Reserved encodings, misalignment, and unsigned sizes on a store all fault.
    assign fault   = (sx_size[1:0] == 2'b11) | (sx_size[2] & sx_size[1])
                   | (sx_size[1:0] == 2'b01 & addr[0])
                   | (sx_size[1:0] == 2'b10 & |addr[1:0])
                   | (sx_size[2] & mem_we);
    assign be_req  = sx_size[1] ? 4'b1111 : (sx_size[0] ? 4'b0011 : 4'b0001) << addr[1:0];
    assign wd_req  = !mem_we ? 32'h0 : sx_size[1] ? wdata
                   : sx_size[0] ? {2{wdata[15:0]}} : {4{wdata[7:0]}};
    assign shifted = dbus_rdata >> {off_q, 3'b000};
    assign ext     = size_q[1] ? shifted
                   : size_q[0] ? {{16{~size_q[2] & shifted[15]}}, shifted[15:0]}
                   : {{24{~size_q[2] & shifted[7]}}, shifted[7:0]};
    assign cnt_inc   = cnt_q + 1'b1;
    assign timed_out = (TIMEOUT != 0) && (cnt_inc == CW'(TIMEOUT));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        off_d   = off_q;
        ld_d    = ld_q;
        lv_d    = 1'b0;
        af_d    = 1'b0;
        err_d   = 1'b0;
        stall   = 1'b0;
        case (state_q)
            IDLE: begin
                if (req && fault) begin
                    af_d = 1'b1;
                end else if (req) begin
                    state_d = ADDR;
                    cnt_d   = '0;
                    valid_d = 1'b1;
                    we_d    = mem_we;
                    addr_d  = {addr[31:2], 2'b00};
                    be_d    = be_req;
                    wdata_d = wd_req;
                    size_d  = sx_size;
                    off_d   = addr[1:0];
                    stall   = 1'b1;
                end
            end
            ADDR: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                if (dbus_ready) begin
                    valid_d = 1'b0;
                    state_d = we_q ? DONE : RESP;
                end else if (timed_out) begin
                    valid_d = 1'b0;
                    err_d   = 1'b1;
                    ld_d    = 32'h0;
                    state_d = DONE;
                end
            end
            RESP: begin
                stall = 1'b1;
                cnt_d = cnt_inc;
                if (dbus_rvalid) begin
                    ld_d    = ext;
                    lv_d    = 1'b1;
                    state_d = DONE;
                end else if (timed_out) begin
                    err_d   = 1'b1;
                    ld_d    = 32'h0;
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            be_q    <= 4'h0;
            wdata_q <= 32'h0;
            size_q  <= 3'h0;
            off_q   <= 2'h0;
            ld_q    <= 32'h0;
            lv_q    <= 1'b0;
            af_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            off_q   <= off_d;
            ld_q    <= ld_d;
            lv_q    <= lv_d;
            af_q    <= af_d;
            err_q   <= err_d;
        end
    end

    assign dbus_valid   = valid_q;
    assign dbus_we      = we_q;
    assign dbus_addr    = addr_q;
    assign dbus_be      = be_q;
    assign dbus_wdata   = wdata_q;
    assign load_data    = ld_q;
    assign load_valid   = lv_q;
    assign access_fault = af_q;
    assign bus_err      = err_q;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed load/store vectors with a queue-based scoreboard for bus requests and responses.
module tb_mem_access_unit;
    logic        clk = 1'b0, rst = 1'b0;
    logic        mem_we = 1'b0, mem_re = 1'b0;
    logic [2:0]  sx_size = 3'h0;
    logic [31:0] addr = 32'h0, wdata = 32'h0;
    logic        dbus_valid, dbus_we, dbus_ready = 1'b0, dbus_rvalid = 1'b0;
    logic [31:0] dbus_addr, dbus_wdata, dbus_rdata = 32'h0, load_data;
    logic [3:0]  dbus_be;
    logic        load_valid, stall, access_fault, bus_err;

    int checks = 0, failures = 0;
    logic [68:0] bus_q[$];
    logic [34:0] resp_q[$];
    logic [31:0] last_ld = 32'h0;

    localparam int K_ST = 0, K_LD = 1, K_FLT = 2, K_TMO = 3;

    mem_access_unit #(.TIMEOUT(4)) dut (
        .clk(clk), .rst(rst), .mem_we(mem_we), .mem_re(mem_re), .sx_size(sx_size),
        .addr(addr), .wdata(wdata), .dbus_valid(dbus_valid), .dbus_ready(dbus_ready),
        .dbus_we(dbus_we), .dbus_addr(dbus_addr), .dbus_be(dbus_be), .dbus_wdata(dbus_wdata),
        .dbus_rvalid(dbus_rvalid), .dbus_rdata(dbus_rdata), .load_data(load_data),
        .load_valid(load_valid), .stall(stall), .access_fault(access_fault), .bus_err(bus_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard whenever the DUT accepts a request or presents a response.
    initial begin
        logic [68:0] eb;
        logic [34:0] er;
        forever begin
            @(negedge clk);
            #1;
            if (dbus_valid && dbus_ready) begin
                checks++;
                if (bus_q.size() == 0) begin
                    failures++;
                    $display("FAIL bus_unexpected actual=%h", {dbus_we, dbus_addr, dbus_be, dbus_wdata});
                end else begin
                    eb = bus_q.pop_front();
                    if ({dbus_we, dbus_addr, dbus_be, dbus_wdata} !== eb) begin
                        failures++;
                        $display("FAIL bus_req actual=%h expected=%h", {dbus_we, dbus_addr, dbus_be, dbus_wdata}, eb);
                    end
                end
            end
            if (load_valid || access_fault || bus_err) begin
                checks++;
                if (resp_q.size() == 0) begin
                    failures++;
                    $display("FAIL resp_unexpected lv=%b af=%b err=%b data=%h", load_valid, access_fault, bus_err, load_data);
                end else begin
                    er = resp_q.pop_front();
                    if ({load_valid, access_fault, bus_err, load_data} !== er) begin
                        failures++;
                        $display("FAIL resp actual=%h expected=%h", {load_valid, access_fault, bus_err, load_data}, er);
                    end
                end
            end
        end
    end

    task automatic do_op(input string name, input logic we, input logic re, input logic [2:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input int rdy, input logic [31:0] rd,
                         input int kind, input logic [31:0] e_addr, input logic [3:0] e_be,
                         input logic [31:0] e_wd, input logic [31:0] e_ld, input int e_stall);
        int stalls = 0, hold = 0, unstable = 0;
        logic acc = 1'b0, done = 1'b0;
        @(posedge clk);
        #1;
        mem_we = we; mem_re = re; sx_size = sz; addr = a; wdata = wd;
        if (kind == K_ST || kind == K_LD) bus_q.push_back({we, e_addr, e_be, e_wd});
        if (kind == K_LD) begin resp_q.push_back({3'b100, e_ld}); last_ld = e_ld; end
        if (kind == K_FLT) resp_q.push_back({3'b010, last_ld});
        if (kind == K_TMO) begin resp_q.push_back({3'b001, 32'h0}); last_ld = 32'h0; end
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (stall) stalls++;
            dbus_rvalid = 1'b0;
            if (acc && re && !we) begin dbus_rvalid = 1'b1; dbus_rdata = rd; end
            acc = 1'b0;
            dbus_ready = 1'b0;
            if (dbus_valid) begin
                if ({dbus_we, dbus_addr, dbus_be, dbus_wdata} !== {we, e_addr, e_be, e_wd}) unstable++;
                if (hold == rdy) begin dbus_ready = 1'b1; acc = 1'b1; end
                else hold++;
            end
            if (!stall) done = 1'b1;
        end
        if (!done) begin
            failures++;
            $display("FAIL %s_hang stall never released", name);
        end
        @(posedge clk);
        #1;
        mem_we = 1'b0; mem_re = 1'b0;
        chk({name, "_stalls"}, 64'(stalls), 64'(e_stall));
        if (kind != K_FLT) chk({name, "_stable"}, 64'(unstable), 64'd0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_valid", 64'(dbus_valid), 64'd0);
        chk("rst_we", 64'(dbus_we), 64'd0);
        chk("rst_addr", 64'(dbus_addr), 64'd0);
        chk("rst_be", 64'(dbus_be), 64'd0);
        chk("rst_wdata", 64'(dbus_wdata), 64'd0);
        chk("rst_ld", 64'(load_data), 64'd0);
        chk("rst_flags", 64'({load_valid, access_fault, bus_err, stall}), 64'd0);

        do_op("lw",   0, 1, 3'b010, 32'h100, 32'h0, 0, 32'hDEADBEEF, K_LD, 32'h100, 4'b1111, 32'h0, 32'hDEADBEEF, 3);
        do_op("lb",   0, 1, 3'b000, 32'h103, 32'h0, 0, 32'h80123456, K_LD, 32'h100, 4'b1000, 32'h0, 32'hFFFFFF80, 3);
        do_op("lbu",  0, 1, 3'b100, 32'h103, 32'h0, 0, 32'h80123456, K_LD, 32'h100, 4'b1000, 32'h0, 32'h00000080, 3);
        do_op("lh",   0, 1, 3'b001, 32'h102, 32'h0, 0, 32'h80123456, K_LD, 32'h100, 4'b1100, 32'h0, 32'hFFFF8012, 3);
        do_op("lhu",  0, 1, 3'b101, 32'h102, 32'h0, 0, 32'h80123456, K_LD, 32'h100, 4'b1100, 32'h0, 32'h00008012, 3);

        // Reset while waiting for the read response; the late rvalid must be ignored.
        @(posedge clk);
        #1 mem_re = 1'b1; sx_size = 3'b010; addr = 32'h400;
        bus_q.push_back({1'b0, 32'h400, 4'b1111, 32'h0});
        @(negedge clk);
        @(negedge clk);
        chk("mid_valid", 64'(dbus_valid), 64'd1);
        dbus_ready = 1'b1;
        @(negedge clk);
        dbus_ready = 1'b0;
        chk("mid_stall", 64'(stall), 64'd1);
        rst = 1'b0; mem_re = 1'b0;
        @(negedge clk);
        chk("mid_rst_bus", 64'({dbus_valid, dbus_we, dbus_be}), 64'd0);
        chk("mid_rst_addr", 64'(dbus_addr), 64'd0);
        chk("mid_rst_ld", 64'(load_data), 64'd0);
        chk("mid_rst_stall", 64'(stall), 64'd0);
        rst = 1'b1; dbus_rvalid = 1'b1; dbus_rdata = 32'h11111111;
        @(negedge clk);
        dbus_rvalid = 1'b0;
        @(negedge clk);
        chk("mid_no_lv", 64'({load_valid, stall, dbus_valid}), 64'd0);
        chk("mid_ld_kept0", 64'(load_data), 64'd0);
        last_ld = 32'h0;

        do_op("lw_d1", 0, 1, 3'b010, 32'h104, 32'h0, 1, 32'h01020304, K_LD, 32'h104, 4'b1111, 32'h0, 32'h01020304, 4);
        do_op("sb",   1, 0, 3'b000, 32'h201, 32'h000000AB, 3, 32'h0, K_ST, 32'h200, 4'b0010, 32'hABABABAB, 32'h0, 5);
        do_op("sh",   1, 0, 3'b001, 32'h206, 32'h1234CDEF, 0, 32'h0, K_ST, 32'h204, 4'b1100, 32'hCDEFCDEF, 32'h0, 2);
        do_op("sw",   1, 0, 3'b010, 32'h300, 32'hCAFEF00D, 0, 32'h0, K_ST, 32'h300, 4'b1111, 32'hCAFEF00D, 32'h0, 2);
        do_op("both", 1, 1, 3'b010, 32'h10C, 32'h55AA55AA, 0, 32'h0, K_ST, 32'h10C, 4'b1111, 32'h55AA55AA, 32'h0, 2);
        do_op("sw_mis", 1, 0, 3'b010, 32'h302, 32'h1, 0, 32'h0, K_FLT, 32'h0, 4'h0, 32'h0, 32'h0, 0);
        do_op("l_rsv",  0, 1, 3'b011, 32'h100, 32'h0, 0, 32'h0, K_FLT, 32'h0, 4'h0, 32'h0, 32'h0, 0);
        do_op("lh_mis", 0, 1, 3'b001, 32'h101, 32'h0, 0, 32'h0, K_FLT, 32'h0, 4'h0, 32'h0, 32'h0, 0);
        do_op("sbu",    1, 0, 3'b100, 32'h200, 32'h0, 0, 32'h0, K_FLT, 32'h0, 4'h0, 32'h0, 32'h0, 0);
        do_op("tmo",  0, 1, 3'b010, 32'h500, 32'h0, 1000, 32'h0, K_TMO, 32'h500, 4'b1111, 32'h0, 32'h0, 5);

        repeat (4) @(negedge clk);
        chk("bus_q_empty", 64'(bus_q.size()), 64'd0);
        chk("resp_q_empty", 64'(resp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
